sram_controller: RTL and testbench

Responder for the Memory stage's data-access port. It converts each 32-bit load/store request from the pipeline into two 16-bit accesses on an external asynchronous SRAM. While an access is in flight it holds `ready` low so the pipeline stalls, then returns read data. It sits between the Memory stage and the board SRAM pins, replacing the ideal single-cycle data memory.

---
 rtl/sram_controller.sv | 182 ++++++++++++++++++
 tb/tb_sram_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
// Data-memory responder for the Memory stage. Each 32-bit load/store becomes two
// 16-bit accesses on an external asynchronous SRAM: the LO phase moves bits
// [15:0] at half-word {w,0}, and the HI phase moves bits [31:16] at {w,1}.
// o_ready stays low while an access is in flight, so the pipeline stalls.
//
// Optional feature macro: SRAM_ADDR_CHECK_EN
//   If it is defined, a request whose address is out of range or misaligned
//   completes at once and pulses o_err. There is no SRAM activity.
//   If it is undefined, the address is truncated silently and o_err is 0.
//
// state | meaning
// IDLE  | waiting for a request; o_ready = no request present
// LO    | low half-word access, ACCESS_CYCLES cycles
// HI    | high half-word access, ACCESS_CYCLES cycles
// DONE  | one-cycle completion, o_ready = 1
//
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_wr_en, i_rd_en             store / load request (held until ready)
//   i_addr, i_wr_data            byte address, store data
//   o_rd_data, o_ready, o_err    load data, handshake, access fault
//   o_sram_addr                  SRAM half-word address
//   o_sram_dq_out, o_sram_dq_oe  SRAM write data and its bus drive enable
//   i_sram_dq_in                 SRAM read data
//   o_sram_we_n                  SRAM write strobe, active-low
// -----------------------------------------------------------------------------
module sram_controller #(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_en,
  input  logic        i_rd_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_rd_data,
  output logic        o_ready,
  output logic        o_err,
  output logic [17:0] o_sram_addr,
  output logic [15:0] o_sram_dq_out,
  output logic        o_sram_dq_oe,
  input  logic [15:0] i_sram_dq_in,
  output logic        o_sram_we_n
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_nxt_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_nxt_cnt;
  logic        r_is_wr;
  logic [16:0] r_word;
  logic [31:0] r_wdata;

  logic        w_req;
  logic        w_last;
  logic        w_bad;
  logic [31:0] w_offset;
  logic [16:0] w_in_word;
  logic        w_op_wr;
  logic [16:0] w_word;
  logic [31:0] w_wdata;
  logic        w_nxt_active;

  assign w_req     = i_wr_en | i_rd_en;
  assign w_last    = (r_cnt == LAST_CNT);
  assign w_offset  = i_addr - BASE_ADDR;
  assign w_in_word = w_offset[18:2];

`ifdef SRAM_ADDR_CHECK_EN
  // Fault: below the base, not word-aligned, or the word index needs more than 17 bits.
  assign w_bad = (i_addr < BASE_ADDR) | (i_addr[1:0] != 2'b00) | (w_offset[31:19] != 13'd0);
`else
  logic w_unused_offset_bits;
  assign w_unused_offset_bits = ^{w_offset[31:19], w_offset[1:0]};
  assign w_bad = 1'b0;
`endif

  // In IDLE the transaction parameters come straight from the request. That lets
  // the first phase's bus values be registered on the same edge that latches them.
  assign w_op_wr = (r_state == S_IDLE) ? i_wr_en   : r_is_wr;
  assign w_word  = (r_state == S_IDLE) ? w_in_word : r_word;
  assign w_wdata = (r_state == S_IDLE) ? i_wr_data : r_wdata;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_nxt_cnt = 4'd0;
        if (w_req) w_nxt_state = w_bad ? S_DONE : S_LO;
      end
      S_LO: begin
        if (w_last) begin
          w_nxt_state = S_HI;
          w_nxt_cnt   = 4'd0;
        end else begin
          w_nxt_cnt = r_cnt + 4'd1;
        end
      end
      S_HI: begin
        if (w_last) begin
          w_nxt_state = S_DONE;
          w_nxt_cnt   = 4'd0;
        end else begin
          w_nxt_cnt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = 4'd0;
      end
    endcase
  end

  assign w_nxt_active = (w_nxt_state == S_LO) || (w_nxt_state == S_HI);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_is_wr       <= 1'b0;
      r_word        <= 17'd0;
      r_wdata       <= 32'd0;
      o_sram_addr   <= 18'd0;
      o_sram_dq_out <= 16'd0;
      o_sram_dq_oe  <= 1'b0;
      o_sram_we_n   <= 1'b1;
      o_rd_data     <= 32'd0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;

      if (r_state == S_IDLE && w_req) begin
        r_is_wr <= i_wr_en;
        r_word  <= w_in_word;
        r_wdata <= i_wr_data;
      end

      if (w_nxt_active) begin
        o_sram_addr  <= {w_word, (w_nxt_state == S_HI)};
        o_sram_dq_oe <= w_op_wr;
        if (w_op_wr)
          o_sram_dq_out <= (w_nxt_state == S_HI) ? w_wdata[31:16] : w_wdata[15:0];
        // The strobe is released for the phase's last cycle, so address and data
        // stay valid one cycle past the rising edge of we_n.
        o_sram_we_n <= ~(w_op_wr && (w_nxt_cnt != LAST_CNT));
      end else begin
        o_sram_dq_oe <= 1'b0;
        o_sram_we_n  <= 1'b1;
      end

      if (!r_is_wr && w_last) begin
        if (r_state == S_LO) o_rd_data[15:0]  <= i_sram_dq_in;
        if (r_state == S_HI) o_rd_data[31:16] <= i_sram_dq_in;
      end
    end
  end

`ifdef SRAM_ADDR_CHECK_EN
  logic r_err;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_err <= 1'b0;
    else       r_err <= (r_state == S_IDLE) && w_req && w_bad;
  end
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  assign o_ready = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

  localparam int          AC   = 2;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          LAT  = 2 * AC + 1;

  logic        i_clk = 0;
  logic        i_rst = 1;
  logic        i_wr_en = 0, i_rd_en = 0;
  logic [31:0] i_addr = 0, i_wr_data = 0;
  logic [31:0] o_rd_data;
  logic        o_ready, o_err;
  logic [17:0] o_sram_addr;
  logic [15:0] o_sram_dq_out;
  logic        o_sram_dq_oe;
  logic [15:0] i_sram_dq_in = 0;
  logic        o_sram_we_n;

  int checks = 0;
  int errors = 0;

  sram_controller #(.ACCESS_CYCLES(AC), .BASE_ADDR(BASE)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_rd_en(i_rd_en),
    .i_addr(i_addr), .i_wr_data(i_wr_data), .o_rd_data(o_rd_data),
    .o_ready(o_ready), .o_err(o_err), .o_sram_addr(o_sram_addr),
    .o_sram_dq_out(o_sram_dq_out), .o_sram_dq_oe(o_sram_dq_oe),
    .i_sram_dq_in(i_sram_dq_in), .o_sram_we_n(o_sram_we_n)
  );

  always #5 i_clk = ~i_clk;

  // External SRAM: async array, written on each clock the strobe is low.
  logic [15:0] sram_mem [logic [17:0]];
  always @(posedge i_clk)
    if (!o_sram_we_n && o_sram_dq_oe) sram_mem[o_sram_addr] = o_sram_dq_out;
  always @(negedge i_clk)
    i_sram_dq_in = sram_mem.exists(o_sram_addr) ? sram_mem[o_sram_addr] : 16'h0000;

  // Reference model: memory as 32-bit words indexed by word number.
  logic [31:0] ref_words [int];
  logic [31:0] last_load = 32'h0;

  function automatic logic [31:0] ref_read(int w);
    return ref_words.exists(w) ? ref_words[w] : 32'h0;
  endfunction

  // Bus monitor: one record for each contiguous strobe-low window.
  typedef struct { logic [17:0] a; logic [15:0] d; int len; } strobe_t;
  strobe_t strobes[$];
  logic    prev_we_n = 1'b1;
  bit      unstable = 0;
  int      ready_req_cnt = 0;

  always @(negedge i_clk) begin
    if (!o_sram_we_n) begin
      if (prev_we_n || strobes.size() == 0) begin
        strobes.push_back('{o_sram_addr, o_sram_dq_out, 1});
      end else begin
        strobe_t t;
        t = strobes[strobes.size()-1];
        if (t.a !== o_sram_addr || t.d !== o_sram_dq_out) unstable = 1;
        t.len = t.len + 1;
        strobes[strobes.size()-1] = t;
      end
      if (o_sram_dq_oe !== 1'b1) unstable = 1;
    end
    prev_we_n = o_sram_we_n;
    if (o_ready && (i_wr_en || i_rd_en)) ready_req_cnt++;
  end

  task automatic clear_mon();
    strobes.delete();
    unstable = 0;
    ready_req_cnt = 0;
  endtask

  // Drives one request, holds it until ready, then drops it.
  // lat is the negedge index (0 = request cycle) at which ready was seen, or -1.
  task automatic do_txn(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rdat, output logic e);
    @(posedge i_clk); #1;
    i_wr_en = wr; i_rd_en = rd; i_addr = a; i_wr_data = d;
    lat = -1; rdat = 'x; e = 'x;
    for (int n = 0; n < 64; n++) begin
      @(negedge i_clk);
      if (o_ready) begin lat = n; rdat = o_rd_data; e = o_err; break; end
    end
    @(posedge i_clk); #1;
    i_wr_en = 0; i_rd_en = 0;
  endtask

  task automatic test_reset();
    i_rst = 1;
    #12;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    checks++; if (o_sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got=%b exp=1", o_sram_we_n); end
    checks++; if (o_sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", o_sram_dq_oe); end
    checks++; if (o_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", o_rd_data); end
    checks++; if (o_sram_addr !== 18'h0 || o_sram_dq_out !== 16'h0) begin errors++;
      $display("FAIL reset_bus got addr=%h dq=%h exp 0/0", o_sram_addr, o_sram_dq_out); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", o_err); end
    i_rst = 0;
  endtask

  task automatic test_store_directed();
    int lat; logic [31:0] rd; logic e;
    clear_mon();
    do_txn(1, 0, 32'd1024, 32'hDEADBEEF, lat, rd, e);
    ref_words[0] = 32'hDEADBEEF;
    checks++; if (lat !== LAT) begin errors++; $display("FAIL store_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (strobes.size() !== 2) begin errors++; $display("FAIL store_strobe_count got=%0d exp=2", strobes.size()); end
    else begin
      checks++; if (strobes[0].a !== 18'd0 || strobes[0].d !== 16'hBEEF || strobes[0].len !== AC-1) begin errors++;
        $display("FAIL store_lo got a=%h d=%h len=%0d exp a=0 d=beef len=%0d", strobes[0].a, strobes[0].d, strobes[0].len, AC-1); end
      checks++; if (strobes[1].a !== 18'd1 || strobes[1].d !== 16'hDEAD || strobes[1].len !== AC-1) begin errors++;
        $display("FAIL store_hi got a=%h d=%h len=%0d exp a=1 d=dead len=%0d", strobes[1].a, strobes[1].d, strobes[1].len, AC-1); end
    end
    checks++; if (unstable) begin errors++; $display("FAIL store_bus_stable got=unstable exp=stable"); end
    checks++; if (rd !== last_load) begin errors++; $display("FAIL store_rd_hold got=%h exp=%h", rd, last_load); end
  endtask

  task automatic test_load_directed();
    int lat; logic [31:0] rd; logic e;
    sram_mem[18'd2] = 16'h1234; sram_mem[18'd3] = 16'hABCD;
    ref_words[1] = 32'hABCD1234;
    clear_mon();
    do_txn(0, 1, 32'd1028, 32'h0, lat, rd, e);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL load_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (rd !== 32'hABCD1234) begin errors++; $display("FAIL load_data got=%h exp=abcd1234", rd); end
    checks++; if (strobes.size() !== 0) begin errors++; $display("FAIL load_no_strobe got=%0d exp=0", strobes.size()); end
    last_load = 32'hABCD1234;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic [31:0] d, rd;
    d = $urandom;
    clear_mon();
    @(posedge i_clk); #1;
    i_wr_en = 1; i_addr = BASE + 32'd20; i_wr_data = d;
    lat1 = -1;
    for (int n = 0; n < 64; n++) begin @(negedge i_clk); if (o_ready) begin lat1 = n; break; end end
    @(posedge i_clk); #1;
    i_wr_en = 0; i_rd_en = 1;
    lat2 = -1; rd = 'x;
    for (int n = 0; n < 64; n++) begin @(negedge i_clk); if (o_ready) begin lat2 = n; rd = o_rd_data; break; end end
    @(posedge i_clk); #1;
    i_rd_en = 0;
    ref_words[5] = d;
    checks++; if (lat1 !== LAT || lat2 !== LAT) begin errors++; $display("FAIL b2b_latency got=%0d/%0d exp=%0d", lat1, lat2, LAT); end
    checks++; if (rd !== d) begin errors++; $display("FAIL b2b_data got=%h exp=%h", rd, d); end
    checks++; if (ready_req_cnt !== 2) begin errors++; $display("FAIL b2b_ready_pulses got=%0d exp=2", ready_req_cnt); end
    last_load = d;
  endtask

  task automatic test_random();
    int lat, w; logic [31:0] rd, d, a; logic e; bit wr, rdn;
    for (int i = 0; i < 24; i++) begin
      w = $urandom_range(0, 15);
      a = BASE + 32'(w * 4);
      d = $urandom;
      case ($urandom_range(0, 3))
        0, 1: begin wr = 1; rdn = 0; end
        2:    begin wr = 0; rdn = 1; end
        default: begin wr = 1; rdn = 1; end
      endcase
      clear_mon();
      do_txn(wr, rdn, a, d, lat, rd, e);
      checks++; if (lat !== LAT || e !== 1'b0) begin errors++; $display("FAIL rand_lat_err i=%0d got lat=%0d err=%b exp %0d/0", i, lat, e, LAT); end
      if (wr) begin
        ref_words[w] = d;
        checks++; if (strobes.size() !== 2 || strobes[0].a !== 18'(2*w) || strobes[0].d !== d[15:0] ||
                      strobes[1].a !== 18'(2*w+1) || strobes[1].d !== d[31:16] || unstable) begin errors++;
          $display("FAIL rand_store i=%0d w=%0d strobes=%0d unstable=%0d exp 2/0", i, w, strobes.size(), unstable); end
      end else begin
        checks++; if (rd !== ref_read(w) || strobes.size() !== 0) begin errors++;
          $display("FAIL rand_load i=%0d w=%0d got=%h exp=%h", i, w, rd, ref_read(w)); end
        last_load = ref_read(w);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd, d, old; logic e;
    d = $urandom;
    old = ref_read(2);
    @(posedge i_clk); #1;
    i_wr_en = 1; i_addr = BASE + 32'd8; i_wr_data = d;
    repeat (AC + 2) @(negedge i_clk);   // first cycle of HI
    checks++; if (o_sram_we_n !== 1'b0 || o_sram_addr !== 18'd5) begin errors++;
      $display("FAIL midrst_in_hi got we_n=%b addr=%h exp 0/5", o_sram_we_n, o_sram_addr); end
    i_rst = 1;
    #1;
    checks++; if (o_sram_we_n !== 1'b1 || o_sram_dq_oe !== 1'b0) begin errors++;
      $display("FAIL midrst_async got we_n=%b oe=%b exp 1/0", o_sram_we_n, o_sram_dq_oe); end
    i_wr_en = 0;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle got ready=%b exp=1", o_ready); end
    #1 i_rst = 0;
    ref_words[2] = {old[31:16], d[15:0]};
    last_load = 32'h0;
    do_txn(0, 1, BASE + 32'd8, 32'h0, lat, rd, e);
    checks++; if (lat !== LAT || rd !== ref_words[2]) begin errors++;
      $display("FAIL midrst_next_load got lat=%0d data=%h exp %0d/%h", lat, rd, LAT, ref_words[2]); end
    last_load = ref_words[2];
  endtask

`ifdef SRAM_ADDR_CHECK_EN
  task automatic test_addr_check();
    int lat; logic [31:0] rd; logic e;
    clear_mon();
    do_txn(0, 1, 32'd1022, 32'h0, lat, rd, e);
    checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL chk_below got lat=%0d err=%b exp 1/1", lat, e); end
    checks++; if (rd !== last_load || strobes.size() !== 0) begin errors++;
      $display("FAIL chk_below_side got rd=%h strobes=%0d exp %h/0", rd, strobes.size(), last_load); end
    clear_mon();
    do_txn(1, 0, 32'd1025, 32'h55AA55AA, lat, rd, e);
    checks++; if (lat !== 1 || e !== 1'b1 || strobes.size() !== 0) begin errors++;
      $display("FAIL chk_misalign got lat=%0d err=%b strobes=%0d exp 1/1/0", lat, e, strobes.size()); end
    do_txn(0, 1, BASE + 32'd4, 32'h0, lat, rd, e);
    checks++; if (lat !== LAT || e !== 1'b0 || rd !== ref_read(1)) begin errors++;
      $display("FAIL chk_valid got lat=%0d err=%b data=%h exp %0d/0/%h", lat, e, rd, LAT, ref_read(1)); end
  endtask
`endif

  initial begin
    test_reset();
    test_store_directed();
    test_load_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef SRAM_ADDR_CHECK_EN
    test_addr_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
